// File: rtl/mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : mem_arbiter
// Brief  : Shares the byte-wide RAM/IO port between 4-byte instruction
//          fetches and byte-granular SLB accesses (SLB has priority).
// Rev    : 1.0
// ----------------------------------------------------------------------------
module mem_arbiter (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        io_buffer_full,
   input  logic        control_hazard,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_valid,
   output logic [31:0] if_data,
   input  logic        slb_access_control,
   input  logic [31:0] slb_mem_addr,
   input  logic        slb_mem_wr,
   input  logic [7:0]  slb_mem_dout,
   output logic        slb_access_valid,
   output logic [7:0]  slb_mem_din,
   output logic [31:0] ram_a,
   output logic        ram_wr,
   output logic [7:0]  ram_dout,
   input  logic [7:0]  ram_din
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_addr;
   logic [2:0]  r_issue_cnt;
   logic [2:0]  r_recv_cnt;
   logic        r_fetch_pending;
   logic [23:0] r_buf;
   logic        r_if_valid;
   logic [31:0] r_if_data;

   logic        w_active;
   logic        w_io_blocked;
   logic        w_slb_grant;
   logic        w_fetch_issue;
   logic        w_capture;
   logic        w_last;
   logic        w_flush;
   logic        w_accept;
   logic [31:0] w_fetch_addr;

   assign w_active      = rdy_in && rst_in;
   // Stores to the IO window (addr[17:16]==3) must wait while the HCI buffer is full.
   assign w_io_blocked  = slb_mem_wr && (slb_mem_addr[17:16] == 2'b11) && io_buffer_full;
   assign w_slb_grant   = w_active && slb_access_control && !w_io_blocked;
   assign w_fetch_issue = w_active && !w_slb_grant && (r_state == S_BUSY) && (r_issue_cnt < 3'd4);
   assign w_capture     = r_fetch_pending;
   assign w_last        = w_capture && (r_recv_cnt == 3'd3);
   assign w_flush       = rdy_in && control_hazard;
   assign w_fetch_addr  = r_addr + {29'd0, r_issue_cnt};

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (rdy_in && if_req && !r_if_valid) begin
               w_state_nxt = S_BUSY;
               w_accept    = 1'b1;
            end
         end
         S_BUSY: begin
            if (w_last) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      if (w_flush) begin
         w_state_nxt = S_IDLE;
         w_accept    = 1'b0;
      end
   end

   always_comb begin
      ram_a    = 32'd0;
      ram_wr   = 1'b0;
      ram_dout = 8'd0;
      if (w_slb_grant) begin
         ram_a    = slb_mem_addr;
         ram_wr   = slb_mem_wr;
         ram_dout = slb_mem_wr ? slb_mem_dout : 8'd0;
      end else if (w_fetch_issue) begin
         ram_a = w_fetch_addr;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         r_state         <= S_IDLE;
         r_addr          <= 32'd0;
         r_issue_cnt     <= 3'd0;
         r_recv_cnt      <= 3'd0;
         r_fetch_pending <= 1'b0;
         r_buf           <= 24'd0;
         r_if_valid      <= 1'b0;
         r_if_data       <= 32'd0;
      end else if (w_flush) begin
         r_state         <= S_IDLE;
         r_issue_cnt     <= 3'd0;
         r_recv_cnt      <= 3'd0;
         r_fetch_pending <= 1'b0;
         r_if_valid      <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_fetch_pending <= w_fetch_issue;
         if (w_accept) begin
            r_addr      <= if_addr;
            r_issue_cnt <= 3'd0;
            r_recv_cnt  <= 3'd0;
         end else begin
            if (w_fetch_issue) begin
               r_issue_cnt <= r_issue_cnt + 3'd1;
            end
            // A byte issued before a stall still lands, even with rdy_in low.
            if (w_capture) begin
               r_recv_cnt <= r_recv_cnt + 3'd1;
               case (r_recv_cnt[1:0])
                  2'd0:    r_buf[7:0]   <= ram_din;
                  2'd1:    r_buf[15:8]  <= ram_din;
                  2'd2:    r_buf[23:16] <= ram_din;
                  default: r_buf        <= r_buf;
               endcase
            end
         end
         if (w_last) begin
            r_if_valid <= 1'b1;
            r_if_data  <= {ram_din, r_buf};
         end else if (rdy_in) begin
            r_if_valid <= 1'b0;
         end
      end
   end

   assign slb_access_valid = w_slb_grant;
   assign slb_mem_din      = ram_din;
   assign if_valid         = r_if_valid;
   assign if_data          = r_if_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module : tb_mem_arbiter
// Brief  : Directed self-checking bench for mem_arbiter with a small RAM model.
// Rev    : 1.0
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        rdy_in;
   logic        io_buffer_full;
   logic        control_hazard;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_valid;
   logic [31:0] if_data;
   logic        slb_access_control;
   logic [31:0] slb_mem_addr;
   logic        slb_mem_wr;
   logic [7:0]  slb_mem_dout;
   logic        slb_access_valid;
   logic [7:0]  slb_mem_din;
   logic [31:0] ram_a;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din = 8'h00;

   int n_vec = 0;
   int n_err = 0;

   mem_arbiter dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .rdy_in             (rdy_in),
      .io_buffer_full     (io_buffer_full),
      .control_hazard     (control_hazard),
      .if_req             (if_req),
      .if_addr            (if_addr),
      .if_valid           (if_valid),
      .if_data            (if_data),
      .slb_access_control (slb_access_control),
      .slb_mem_addr       (slb_mem_addr),
      .slb_mem_wr         (slb_mem_wr),
      .slb_mem_dout       (slb_mem_dout),
      .slb_access_valid   (slb_access_valid),
      .slb_mem_din        (slb_mem_din),
      .ram_a              (ram_a),
      .ram_wr             (ram_wr),
      .ram_dout           (ram_dout),
      .ram_din            (ram_din)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [7:0] rd(input logic [31:0] a);
      case (a)
         32'h0000_0100: rd = 8'h13;
         32'h0000_0101: rd = 8'h00;
         32'h0000_0102: rd = 8'h00;
         32'h0000_0103: rd = 8'h00;
         32'h0000_0200: rd = 8'h11;
         32'h0000_0201: rd = 8'h22;
         32'h0000_0202: rd = 8'h33;
         32'h0000_0203: rd = 8'h44;
         32'h0000_0400: rd = 8'hEF;
         32'h0000_0401: rd = 8'hBE;
         32'h0000_0402: rd = 8'hAD;
         32'h0000_0403: rd = 8'hDE;
         32'h0000_1000: rd = 8'hA5;
         default:       rd = a[7:0] ^ 8'h5A;
      endcase
   endfunction

   // Read data appears one cycle after the address.
   always @(posedge clk_in) ram_din <= rd(ram_a);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk_in);
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0; control_hazard = 1'b0;
      if_req = 1'b0; if_addr = 32'd0;
      slb_access_control = 1'b1; slb_mem_addr = 32'h1234; slb_mem_wr = 1'b1; slb_mem_dout = 8'h77;
      settle();
      chk("rst_slb_valid", {31'd0, slb_access_valid}, 32'd0);
      chk("rst_ram_a", ram_a, 32'd0);
      chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
      chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
      chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
      chk("rst_if_data", if_data, 32'd0);
      slb_access_control = 1'b0; slb_mem_wr = 1'b0;

      tick(); rst_in = 1'b1; settle();
      chk("idle_ram_a", ram_a, 32'd0);

      // Reset asserted mid-fetch
      tick(); if_req = 1'b1; if_addr = 32'h300; settle();
      tick(); settle(); chk("rb_a0", ram_a, 32'h300);
      tick(); settle(); chk("rb_a1", ram_a, 32'h301);
      rst_in = 1'b0; #1;
      chk("rb_async_a", ram_a, 32'd0);
      chk("rb_async_v", {31'd0, if_valid}, 32'd0);
      tick(); rst_in = 1'b1; if_req = 1'b0; settle();
      chk("rb_state_idle", ram_a, 32'd0);

      // Uncontended fetch of 0x100
      tick(); if_req = 1'b1; if_addr = 32'h100; settle();
      chk("f1_c0_a", ram_a, 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick(); settle();
         chk("f1_issue_a", ram_a, 32'h100 + i);
         chk("f1_issue_wr", {31'd0, ram_wr}, 32'd0);
      end
      tick(); settle();
      chk("f1_c5_v", {31'd0, if_valid}, 32'd0);
      chk("f1_c5_a", ram_a, 32'd0);
      tick(); settle();
      chk("f1_c6_v", {31'd0, if_valid}, 32'd1);
      chk("f1_c6_d", if_data, 32'h0000_0013);
      tick(); if_req = 1'b0; settle();
      chk("f1_c7_v", {31'd0, if_valid}, 32'd0);
      chk("f1_req_ignored", ram_a, 32'd0);

      // SLB read preempts fetch of 0x200
      tick(); if_req = 1'b1; if_addr = 32'h200; settle();
      tick(); settle(); chk("sp_c1_a", ram_a, 32'h200);
      tick(); slb_access_control = 1'b1; slb_mem_addr = 32'h1000; slb_mem_wr = 1'b0; settle();
      chk("sp_c2_grant", {31'd0, slb_access_valid}, 32'd1);
      chk("sp_c2_a", ram_a, 32'h1000);
      tick(); slb_access_control = 1'b0; settle();
      chk("sp_c3_a", ram_a, 32'h201);
      chk("sp_c3_din", {24'd0, slb_mem_din}, 32'h0000_00A5);
      tick(); settle(); chk("sp_c4_a", ram_a, 32'h202);
      tick(); settle(); chk("sp_c5_a", ram_a, 32'h203);
      tick(); settle(); chk("sp_c6_v", {31'd0, if_valid}, 32'd0);
      tick(); settle();
      chk("sp_c7_v", {31'd0, if_valid}, 32'd1);
      chk("sp_c7_d", if_data, 32'h4433_2211);
      tick(); if_req = 1'b0; settle();

      // IO backpressure on store to 0x30000
      tick(); slb_access_control = 1'b1; slb_mem_addr = 32'h30000; slb_mem_wr = 1'b1;
      slb_mem_dout = 8'h41; io_buffer_full = 1'b1; settle();
      chk("io_c0_grant", {31'd0, slb_access_valid}, 32'd0);
      chk("io_c0_wr", {31'd0, ram_wr}, 32'd0);
      tick(); settle();
      chk("io_c1_grant", {31'd0, slb_access_valid}, 32'd0);
      tick(); settle();
      chk("io_c2_wr", {31'd0, ram_wr}, 32'd0);
      tick(); io_buffer_full = 1'b0; settle();
      chk("io_c3_grant", {31'd0, slb_access_valid}, 32'd1);
      chk("io_c3_wr", {31'd0, ram_wr}, 32'd1);
      chk("io_c3_dout", {24'd0, ram_dout}, 32'h41);
      chk("io_c3_a", ram_a, 32'h30000);
      tick(); slb_mem_wr = 1'b0; io_buffer_full = 1'b1; settle();
      chk("io_rd_grant", {31'd0, slb_access_valid}, 32'd1);
      chk("io_rd_wr", {31'd0, ram_wr}, 32'd0);
      chk("io_rd_dout", {24'd0, ram_dout}, 32'd0);
      tick(); slb_access_control = 1'b0; io_buffer_full = 1'b0; settle();

      // Flush in cycle 3 (if_req still high), then fetch 0x400
      tick(); if_req = 1'b1; if_addr = 32'h500; settle();
      tick(); settle(); chk("fl_c1_a", ram_a, 32'h500);
      tick(); settle(); chk("fl_c2_a", ram_a, 32'h501);
      tick(); control_hazard = 1'b1; settle();
      tick(); control_hazard = 1'b0; if_addr = 32'h400; settle();
      chk("fl_c4_idle", ram_a, 32'd0);
      chk("fl_c4_v", {31'd0, if_valid}, 32'd0);
      tick(); settle(); chk("fl_c5_a", ram_a, 32'h400);
      tick(); settle(); chk("fl_c6_a", ram_a, 32'h401);
      tick(); settle(); chk("fl_c7_v", {31'd0, if_valid}, 32'd0);
      tick(); settle(); chk("fl_c8_a", ram_a, 32'h403);
      tick(); settle(); chk("fl_c9_v", {31'd0, if_valid}, 32'd0);
      tick(); settle();
      chk("fl_c10_v", {31'd0, if_valid}, 32'd1);
      chk("fl_c10_d", if_data, 32'hDEAD_BEEF);
      tick(); if_req = 1'b0; settle();

      // Two-cycle stall after byte 1 issue
      tick(); if_req = 1'b1; if_addr = 32'h200; settle();
      tick(); settle(); chk("st_c1_a", ram_a, 32'h200);
      tick(); settle(); chk("st_c2_a", ram_a, 32'h201);
      tick(); rdy_in = 1'b0; slb_access_control = 1'b1; slb_mem_addr = 32'h1000; slb_mem_wr = 1'b0; settle();
      chk("st_c3_grant", {31'd0, slb_access_valid}, 32'd0);
      chk("st_c3_a", ram_a, 32'd0);
      tick(); slb_access_control = 1'b0; settle();
      chk("st_c4_a", ram_a, 32'd0);
      tick(); rdy_in = 1'b1; settle(); chk("st_c5_a", ram_a, 32'h202);
      tick(); settle(); chk("st_c6_a", ram_a, 32'h203);
      tick(); settle(); chk("st_c7_v", {31'd0, if_valid}, 32'd0);
      tick(); settle();
      chk("st_c8_v", {31'd0, if_valid}, 32'd1);
      chk("st_c8_d", if_data, 32'h4433_2211);
      tick(); if_req = 1'b0; settle();

      // Address wrap
      tick(); if_req = 1'b1; if_addr = 32'hFFFF_FFFE; settle();
      tick(); settle(); chk("wr_a0", ram_a, 32'hFFFF_FFFE);
      tick(); settle(); chk("wr_a1", ram_a, 32'hFFFF_FFFF);
      tick(); settle(); chk("wr_a2", ram_a, 32'h0000_0000);
      tick(); settle(); chk("wr_a3", ram_a, 32'h0000_0001);
      tick(); settle();
      tick(); settle();
      chk("wr_v", {31'd0, if_valid}, 32'd1);
      chk("wr_d", if_data, 32'h5B5A_A5A4);
      tick(); if_req = 1'b0; settle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
